// File: rtl/register_file_pkg.sv
// Shared processor constants: register width, index width and register count.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Two-read, one-write register file with x0 hardwired to zero.
// Reads are combinational; writes and the synchronous clear land on the rising clock edge.
module register_file #(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] registers [NREGS];

    // Reset wins over a simultaneous write; writes to index 0 are dropped so x0 stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                registers[i] <= '0;
            end
        end else if (reg_write && (rd != '0)) begin
            registers[rd] <= write_data;
        end
    end

    // No write-through: a same-index read shows the old value until the edge.
    assign read_data1 = (rs1 == '0) ? '0 : registers[rs1];
    assign read_data2 = (rs2 == '0) ? '0 : registers[rs2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, writes, x0 protection,
// isolation, reset priority and read-during-write ordering.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [DW-1:0] write_data;
    logic          reg_write;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    int checks   = 0;
    int failures = 0;

    register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .write_data(write_data),
        .reg_write (reg_write),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] data);
        rd         = idx;
        write_data = data;
        reg_write  = 1'b1;
        tick();
        reg_write  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        rs1        = '0;
        rs2        = '0;
        rd         = '0;
        write_data = '0;
        reg_write  = 1'b0;

        // Reset for one cycle: every entry cleared, reads return zero.
        tick();
        reset = 1'b0;
        #1;
        check("reset_reg0", dut.registers[0], 32'h0);
        check("reset_reg1", dut.registers[1], 32'h0);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("reset_all[%0d]", i), dut.registers[i], 32'h0);
        end
        rs1 = 5'd0;
        rs2 = 5'd1;
        #1;
        check("reset_rd1", read_data1, 32'h0);
        check("reset_rd2", read_data2, 32'h0);

        // Write then read on both ports.
        write_reg(5'd5, 32'hABCD1234);
        rs1 = 5'd5;
        rs2 = 5'd5;
        #1;
        check("wr5_rd1", read_data1, 32'hABCD1234);
        check("wr5_rd2", read_data2, 32'hABCD1234);

        write_reg(5'd9, 32'h12345678);
        rs1 = 5'd9;
        rs2 = 5'd9;
        #1;
        check("wr9_rd1", read_data1, 32'h12345678);
        check("wr9_rd2", read_data2, 32'h12345678);

        // Independent ports addressing different registers.
        rs1 = 5'd5;
        rs2 = 5'd9;
        #1;
        check("indep_rd1", read_data1, 32'hABCD1234);
        check("indep_rd2", read_data2, 32'h12345678);

        // reg_write low: nothing changes.
        rd         = 5'd5;
        write_data = 32'h55555555;
        reg_write  = 1'b0;
        tick();
        check("nowrite_reg5", dut.registers[5], 32'hABCD1234);
        check("nowrite_rd1", read_data1, 32'hABCD1234);

        // x0 protection.
        write_reg(5'd0, 32'hFFFFFFFF);
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        check("x0_reg0", dut.registers[0], 32'h0);
        check("x0_rd1", read_data1, 32'h0);
        check("x0_rd2", read_data2, 32'h0);
        check("x0_keep5", dut.registers[5], 32'hABCD1234);
        check("x0_keep9", dut.registers[9], 32'h12345678);

        // Read during write to the same index: old before the edge, new after.
        write_reg(5'd7, 32'h11111111);
        rs1        = 5'd7;
        rs2        = 5'd7;
        rd         = 5'd7;
        write_data = 32'h22222222;
        reg_write  = 1'b1;
        #1;
        check("rdw_before_rd1", read_data1, 32'h11111111);
        check("rdw_before_rd2", read_data2, 32'h11111111);
        tick();
        reg_write = 1'b0;
        check("rdw_after_rd1", read_data1, 32'h22222222);
        check("rdw_after_rd2", read_data2, 32'h22222222);

        // Reset after write discards data.
        write_reg(5'd10, 32'h98765432);
        check("pre_reset_reg10", dut.registers[10], 32'h98765432);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_reset_reg10", dut.registers[10], 32'h0);
        check("post_reset_reg5", dut.registers[5], 32'h0);
        check("post_reset_reg7", dut.registers[7], 32'h0);
        rs1 = 5'd31;
        rs2 = 5'd31;
        #1;
        check("post_reset_rd1", read_data1, 32'h0);
        check("post_reset_rd2", read_data2, 32'h0);

        // Isolation: one write leaves neighbours at zero.
        write_reg(5'd15, 32'hDEADBEEF);
        rs1 = 5'd8;
        rs2 = 5'd16;
        #1;
        check("iso_rd1_x8", read_data1, 32'h0);
        check("iso_rd2_x16", read_data2, 32'h0);
        rs1 = 5'd15;
        rs2 = 5'd14;
        #1;
        check("iso_rd1_x15", read_data1, 32'hDEADBEEF);
        check("iso_rd2_x14", read_data2, 32'h0);

        // Top index writable.
        write_reg(5'd31, 32'hCAFEF00D);
        rs2 = 5'd31;
        #1;
        check("top_rd2_x31", read_data2, 32'hCAFEF00D);
        check("top_rd1_x15", read_data1, 32'hDEADBEEF);

        // Reset has priority over a simultaneous write.
        write_reg(5'd3, 32'h00000077);
        rd         = 5'd3;
        write_data = 32'h00000001;
        reg_write  = 1'b1;
        reset      = 1'b1;
        tick();
        reset     = 1'b0;
        reg_write = 1'b0;
        check("rst_prio_reg3", dut.registers[3], 32'h0);
        check("rst_prio_reg15", dut.registers[15], 32'h0);
        rs1 = 5'd3;
        #1;
        check("rst_prio_rd1", read_data1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of each register and data port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the width of the register index (2**ADDR_WIDTH registers).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high clear of all registers.
- rs1  input  ADDR_WIDTH  read-port-1 register index.
- rs2  input  ADDR_WIDTH  read-port-2 register index.
- rd  input  ADDR_WIDTH  write-port register index.
- write_data  input  DATA_WIDTH  data to write.
- reg_write  input  1  write enable.
- read_data1  output  DATA_WIDTH  contents of register rs1.
- read_data2  output  DATA_WIDTH  contents of register rs2.

Function
REQ-004 Storage SHALL be an array named `registers` of 2**ADDR_WIDTH entries of DATA_WIDTH bits, reachable hierarchically as `registers[i]`.
REQ-005 Reads SHALL be combinational: read_data1 = registers[rs1] and read_data2 = registers[rs2], with zero clock latency.
REQ-006 A read of index 0 on either port SHALL return 0.
REQ-007 On a rising clk edge with reset=0, reg_write=1 and rd!=0, registers[rd] SHALL take write_data.
REQ-008 A write SHALL become visible on the read ports immediately after that clock edge.
REQ-009 A write with rd=0 SHALL be ignored, so registers[0] stays 0 at all times.
REQ-010 When reg_write=0, no register SHALL change.
REQ-011 Read-during-write to the same index SHALL return the old value until the edge (no write-through bypass).
REQ-012 Both read ports SHALL be fully independent and may address the same or different registers in the same cycle.
REQ-013 A write to one index SHALL leave every other register unchanged.
REQ-014 Outputs SHALL contain no X when all inputs are known and reset has been applied at least once.

Reset
REQ-015 On a rising clk edge with reset=1, every register, including registers[0], SHALL become 0.
REQ-016 Reset SHALL take priority over a simultaneous write.
REQ-017 Reset asserted mid-operation SHALL discard all previously written data.
REQ-018 After reset, read_data1 and read_data2 SHALL be 0 for any rs1/rs2.
REQ-019 Reset SHALL have no asynchronous effect; before the first clock edge under reset, register contents are undefined.

Structure
REQ-020 DATA_WIDTH, ADDR_WIDTH and NUM_REGS (= 2**ADDR_WIDTH) SHALL be defined as constants in the shared processor package and used as parameter defaults.
REQ-021 The block SHALL be a single module with no sub-modules: one clocked process for reset and write, plus combinational read assigns.

Verification
REQ-022 Reset: assert reset for 1 cycle -> registers[0]=0, registers[1]=0, and all 32 entries are 0.
REQ-023 Write then read: rd=5, write_data=0xABCD1234, reg_write=1 for 1 cycle; then rs1=rs2=5 -> read_data1=read_data2=0xABCD1234. Repeat with rd=9, 0x12345678 -> 0x12345678 on both ports.
REQ-024 x0 protection: rd=0, write_data=0xFFFFFFFF, reg_write=1 for 1 cycle -> registers[0]=0, and reads of index 0 return 0.
REQ-025 Reset after write: write 0x98765432 to x10, then 1 cycle of reset -> registers[10]=0; rs1=rs2=31 -> both outputs 0.
REQ-026 Isolation: write 0xDEADBEEF to x15 after reset; rs1=8, rs2=16 -> both outputs 0; rs1=15 -> 0xDEADBEEF.
REQ-027 Corner cases: reset=1 and reg_write=1 (rd=3, 0x1) in the same cycle -> registers[3]=0; same-cycle read of rd during a write -> old value before the edge, new value after it.
